serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_one_bit.sv | 18 +
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : FSM state encoding (2 bits): ST_IDLE, ST_SHIFT, ST_DONE
//   DEFAULT_WIDTH : default operand/result width
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_one_bit.sv
// One-bit full subtractor cell: computes a - b - b_in.
//   a, b  : operand bits
//   b_in  : incoming borrow
//   d     : difference bit
//   b_out : outgoing borrow
module one_bit_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = a ^ b ^ b_in;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule : one_bit_full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH), one bit per clock, LSB first.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : launch request, sampled only in IDLE
//   a, b        : minuend / subtrahend, captured on the accepting edge
//   busy        : high while shifting
//   done        : one-cycle completion pulse
//   diff        : last completed result, held until the next completion
//   borrow_out  : final borrow of the last result (1 means a < b)
//   dbg_state   : current FSM state, for observation only
//
// Handshake: start is taken on a rising edge only while IDLE; the operation
// then runs WIDTH shift cycles, raises done for one cycle with diff/borrow_out
// updated on that same edge, and returns to IDLE. Requests outside IDLE are
// dropped, not queued.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output state_t           dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sr, b_sr;
    // Only WIDTH-1 result bits need storing; the last bit comes straight
    // from the cell on the completing edge.
    logic [WIDTH-2:0] res_q;
    logic             bw_q;

    logic             load, shift;
    logic             cell_d, cell_bw;
    logic [WIDTH-1:0] res_full;

    one_bit_full_subtractor u_cell (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .b_in  (bw_q),
        .d     (cell_d),
        .b_out (cell_bw)
    );

    assign res_full  = {cell_d, res_q};
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    load    = 1'b1;
                end
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (cnt_q == LAST_CNT) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            a_sr       <= '0;
            b_sr       <= '0;
            res_q      <= '0;
            bw_q       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (state_d == ST_SHIFT);
            done <= (state_d == ST_DONE);
            if (load) begin
                a_sr  <= a;
                b_sr  <= b;
                res_q <= '0;
                bw_q  <= 1'b0;
                cnt_q <= '0;
            end else if (shift) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                res_q <= res_full[WIDTH-1:1];
                bw_q  <= cell_bw;
                cnt_q <= cnt_q + 1'b1;
                if (state_d == ST_DONE) begin
                    diff       <= res_full;
                    borrow_out <= cell_bw;
                end
            end
        end
    end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
    state_t       dbg_state;

    int n_checks = 0;
    int n_fails  = 0;

    logic [W:0] exp_q[$];       // {borrow, diff} expected per launched op
    logic [W:0] held = '0;      // last result the outputs must be holding

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: unsigned subtraction modulo 2^W, borrow when a < b.
    function automatic logic [W:0] ref_sub(input int unsigned av, input int unsigned bv);
        int unsigned m;
        m = 1 << W;
        return {1'(av < bv), W'((av + m - bv) % m)};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W:0] obs;
        logic [W:0] exp_v;
        if (rst_n) begin
            obs = {borrow_out, diff};
            check("busy_done_excl", 64'(busy & done), 64'd0);
            if (done) begin
                check("done_has_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    check("result", 64'(obs), 64'(exp_v));
                end
                held = obs;
            end else begin
                check("result_hold", 64'(obs), 64'(held));
            end
        end
    end

    // ---------------- drivers ----------------
    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        exp_q.push_back(ref_sub(av, bv));
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
            end
            check("busy_timing", 64'(busy), 64'(k <= W));
            check("done_timing", 64'(done), 64'(k == W + 1));
        end
        @(negedge clk);
        check("back_to_idle", 64'(busy | done), 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] dir_a[6];
        logic [W-1:0] dir_b[6];
        int done_hits;
        dir_a = '{8'h05, 8'h03, 8'h00, 8'hA5, 8'hFF, 8'h00};
        dir_b = '{8'h03, 8'h05, 8'h01, 8'hA5, 8'h00, 8'h00};

        // reset state
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_borrow", 64'(borrow_out), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // directed vectors
        for (int i = 0; i < 6; i++) begin
            run_op(dir_a[i], dir_b[i]);
            idle_cycles(i % 3);
        end
        // equal operands: result holds 0 through idle (monitor checks hold)
        run_op(8'hA5, 8'hA5);
        idle_cycles(5);
        check("hold_zero_diff", 64'(diff), 64'd0);

        // start re-pulsed and operands changed mid-operation
        a = 8'h80;
        b = 8'h01;
        start = 1'b1;
        exp_q.push_back(ref_sub(32'h80, 32'h01));
        done_hits = 0;
        for (int k = 1; k <= W + 6; k++) begin
            @(negedge clk);
            start = (k == 3);
            if (k == 3) begin
                a = 8'h00;
                b = 8'hFF;
            end
            if (k == 5) begin
                a = 8'h55;
                b = 8'hAA;
            end
            if (done) done_hits++;
            check("ignore_done_timing", 64'(done), 64'(k == W + 1));
        end
        check("ignore_done_count", 64'(done_hits), 64'd1);
        check("ignore_diff", 64'(diff), 64'h7F);
        check("ignore_borrow", 64'(borrow_out), 64'd0);

        // asynchronous reset mid-operation
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        @(posedge clk);             // E0
        #1 start = 1'b0;
        repeat (4) @(posedge clk);  // E1..E4
        #2 rst_n = 1'b0;
        exp_q.delete();
        held = '0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_diff", 64'(diff), 64'd0);
        check("midrst_borrow", 64'(borrow_out), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h10, 8'h01);
        check("post_rst_diff", 64'(diff), 64'h0F);

        // start held high: one launch every W+2 cycles
        a = 8'h09;
        b = 8'h04;
        start = 1'b1;
        for (int j = 0; j < 3; j++) exp_q.push_back(ref_sub(32'h09, 32'h04));
        done_hits = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) done_hits++;
            check("held_done_timing", 64'(done), 64'((k % (W + 2)) == W + 1));
        end
        start = 1'b0;
        check("held_done_count", 64'(done_hits), 64'd3);
        check("held_diff", 64'(diff), 64'h05);
        idle_cycles(3);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom_range(255, 0)));
            idle_cycles($urandom_range(2, 0));
        end
        check("all_results_seen", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_serial_subtractor
